// File: rtl/lcd_win_ctrl.sv
// Window/cursor sequencer behind the LCD receive interface: CASET/PASET windowing, RAMWR/RAMWRC pixel streaming.
// Optional MADCTL (0x36, MV bit) column-major traversal is enabled by defining LCD_WIN_CTRL_MADCTL_EN.
module lcd_win_ctrl #(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int X_W   = 9,
    parameter int Y_W   = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [7:0]     i_command,
    input  logic           i_command_latch,
    input  logic [7:0]     i_param,
    input  logic           i_param_latch,
    input  logic [15:0]    i_rgb565,
    input  logic           i_rgb565_latch,
    output logic [X_W-1:0] o_fb_x,
    output logic [Y_W-1:0] o_fb_y,
    output logic [15:0]    o_fb_data,
    output logic           o_fb_valid,
    input  logic           i_fb_ready,
    output logic           o_frame_start,
    output logic           o_frame_done,
    output logic           o_overrun
);

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;
`ifdef LCD_WIN_CTRL_MADCTL_EN
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
`endif

    localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_PASET,
        S_WRITE
`ifdef LCD_WIN_CTRL_MADCTL_EN
        , S_MADCTL
`endif
    } state_t;

    state_t state, next_state;

    logic [X_W-1:0] sc, ec, win_sc, win_ec, cur_x, nxt_x, eff_ec;
    logic [Y_W-1:0] sp, ep, win_sp, win_ep, cur_y, nxt_y, eff_ep;
    logic [2:0]     param_cnt;   // bit 2 set once the 4th parameter has been taken
    logic [15:0]    param_start;
    logic [7:0]     param_end_hi;
    logic           mv;
    logic           pix_go;

    function automatic logic [X_W-1:0] clamp_x(input logic [15:0] v);
        return (v > 16'(H_RES - 1)) ? X_MAX : v[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [15:0] v);
        return (v > 16'(V_RES - 1)) ? Y_MAX : v[Y_W-1:0];
    endfunction

    assign eff_ec = (sc > ec) ? sc : ec;
    assign eff_ep = (sp > ep) ? sp : ep;
    assign pix_go = i_rgb565_latch && !i_command_latch && !i_param_latch && (state == S_WRITE);

`ifndef LCD_WIN_CTRL_MADCTL_EN
    assign mv = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (i_rst) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: assign a default first so no path leaves next_state unassigned (no inferred latch).
        next_state = state;
        if (i_command_latch) begin
            case (i_command)
                CMD_CASET:   next_state = S_CASET;
                CMD_PASET:   next_state = S_PASET;
                CMD_RAMWR,
                CMD_RAMWRC:  next_state = S_WRITE;
                CMD_NOP:     next_state = state;
`ifdef LCD_WIN_CTRL_MADCTL_EN
                CMD_MADCTL:  next_state = S_MADCTL;
`endif
                default:     next_state = S_IDLE;
            endcase
        end
    end

    // Cursor successor inside the latched window; MV swaps the fast axis.
    always_comb begin
        nxt_x = cur_x;
        nxt_y = cur_y;
        if (!mv) begin
            if (cur_x < win_ec) nxt_x = cur_x + 1'b1;
            else begin
                nxt_x = win_sc;
                nxt_y = (cur_y < win_ep) ? cur_y + 1'b1 : win_sp;
            end
        end else begin
            if (cur_y < win_ep) nxt_y = cur_y + 1'b1;
            else begin
                nxt_y = win_sp;
                nxt_x = (cur_x < win_ec) ? cur_x + 1'b1 : win_sc;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sc <= '0;  ec <= X_MAX;  sp <= '0;  ep <= Y_MAX;
            win_sc <= '0;  win_ec <= X_MAX;  win_sp <= '0;  win_ep <= Y_MAX;
            cur_x <= '0;  cur_y <= '0;
            param_cnt <= '0;  param_start <= '0;  param_end_hi <= '0;
            o_fb_x <= '0;  o_fb_y <= '0;  o_fb_data <= '0;  o_fb_valid <= 1'b0;
            o_frame_start <= 1'b0;  o_frame_done <= 1'b0;  o_overrun <= 1'b0;
`ifdef LCD_WIN_CTRL_MADCTL_EN
            mv <= 1'b0;
`endif
        end else begin
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            if (o_fb_valid && i_fb_ready) o_fb_valid <= 1'b0;

            if (i_command_latch) begin
                param_cnt <= '0;
                case (i_command)
                    CMD_RAMWR: begin
                        win_sc <= sc;  win_ec <= eff_ec;  win_sp <= sp;  win_ep <= eff_ep;
                        cur_x <= sc;  cur_y <= sp;
                        o_frame_start <= 1'b1;
                    end
                    CMD_RAMWRC: begin
                        win_sc <= sc;  win_ec <= eff_ec;  win_sp <= sp;  win_ep <= eff_ep;
                    end
                    CMD_SWRESET: begin
                        sc <= '0;  ec <= X_MAX;  sp <= '0;  ep <= Y_MAX;
                        win_sc <= '0;  win_ec <= X_MAX;  win_sp <= '0;  win_ep <= Y_MAX;
                        cur_x <= '0;  cur_y <= '0;
                        o_overrun <= 1'b0;
                        o_fb_valid <= 1'b0;
`ifdef LCD_WIN_CTRL_MADCTL_EN
                        mv <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end else if (i_param_latch) begin
                if (!param_cnt[2] && (state == S_CASET || state == S_PASET)) begin
                    param_cnt <= param_cnt + 3'd1;
                    case (param_cnt[1:0])
                        2'd0: param_start[15:8] <= i_param;
                        2'd1: param_start[7:0]  <= i_param;
                        2'd2: param_end_hi      <= i_param;
                        default: begin
                            if (state == S_CASET) begin
                                sc <= clamp_x(param_start);
                                ec <= clamp_x({param_end_hi, i_param});
                            end else begin
                                sp <= clamp_y(param_start);
                                ep <= clamp_y({param_end_hi, i_param});
                            end
                        end
                    endcase
                end
`ifdef LCD_WIN_CTRL_MADCTL_EN
                if (state == S_MADCTL && param_cnt == 3'd0) begin
                    mv        <= i_param[5];
                    param_cnt <= 3'd1;
                end
`endif
            end else if (pix_go) begin
                // A stalled beat wins over the new pixel; the cursor stays put.
                if (o_fb_valid && !i_fb_ready) begin
                    o_overrun <= 1'b1;
                end else begin
                    o_fb_valid   <= 1'b1;
                    o_fb_x       <= cur_x;
                    o_fb_y       <= cur_y;
                    o_fb_data    <= i_rgb565;
                    o_frame_done <= (cur_x == win_ec) && (cur_y == win_ep);
                    cur_x        <= nxt_x;
                    cur_y        <= nxt_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Self-checking bench for lcd_win_ctrl: directed scenarios pinned by literal beats, then randomized
// command/parameter/pixel traffic compared every cycle against an integer reference model.
module tb_lcd_win_ctrl;

    localparam int H_RES = 320;
    localparam int V_RES = 240;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_command = '0;
    logic        i_command_latch = 1'b0;
    logic [7:0]  i_param = '0;
    logic        i_param_latch = 1'b0;
    logic [15:0] i_rgb565 = '0;
    logic        i_rgb565_latch = 1'b0;
    logic        i_fb_ready = 1'b1;
    logic [8:0]  o_fb_x;
    logic [7:0]  o_fb_y;
    logic [15:0] o_fb_data;
    logic        o_fb_valid, o_frame_start, o_frame_done, o_overrun;

    lcd_win_ctrl dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_command(i_command), .i_command_latch(i_command_latch),
        .i_param(i_param), .i_param_latch(i_param_latch),
        .i_rgb565(i_rgb565), .i_rgb565_latch(i_rgb565_latch),
        .o_fb_x(o_fb_x), .o_fb_y(o_fb_y), .o_fb_data(o_fb_data),
        .o_fb_valid(o_fb_valid), .i_fb_ready(i_fb_ready),
        .o_frame_start(o_frame_start), .o_frame_done(o_frame_done), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    bit rand_rdy = 1'b0;

    typedef struct { int x; int y; int d; bit done; } beat_t;
    beat_t log_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain integers, spec rules) ----------------
    int m_sc, m_ec, m_sp, m_ep, w_sc, w_ec, w_sp, w_ep, cx, cy;
    int mode;                 // 0 idle, 1 column set, 2 page set, 3 write, 4 madctl
    int pidx, mdl_s, mdl_e;
    int pb[4];
    bit m_valid, m_start, m_done, m_ovr, m_mv, stall;
    int m_x, m_y, m_data;

    task automatic model_window_reset();
        m_sc = 0; m_ec = H_RES - 1; m_sp = 0; m_ep = V_RES - 1;
        w_sc = 0; w_ec = H_RES - 1; w_sp = 0; w_ep = V_RES - 1;
        cx = 0; cy = 0;
    endtask

    task automatic model_latch_window();
        w_sc = m_sc; w_sp = m_sp;
        w_ec = (m_ec > m_sc) ? m_ec : m_sc;
        w_ep = (m_ep > m_sp) ? m_ep : m_sp;
    endtask

    task automatic model_advance();
        if (!m_mv) begin
            if (cx < w_ec) cx++;
            else begin cx = w_sc; cy = (cy < w_ep) ? cy + 1 : w_sp; end
        end else begin
            if (cy < w_ep) cy++;
            else begin cy = w_sp; cx = (cx < w_ec) ? cx + 1 : w_sc; end
        end
    endtask

    always @(posedge clk) begin
        if (i_rst) begin
            model_window_reset();
            mode = 0; pidx = 0; m_mv = 0;
            m_valid = 0; m_start = 0; m_done = 0; m_ovr = 0;
            m_x = 0; m_y = 0; m_data = 0;
        end else begin
            stall = m_valid && !i_fb_ready;
            m_start = 0; m_done = 0;
            if (m_valid && i_fb_ready) m_valid = 0;
            if (i_command_latch) begin
                pidx = 0;
                case (i_command)
                    8'h2A: mode = 1;
                    8'h2B: mode = 2;
                    8'h2C: begin model_latch_window(); cx = w_sc; cy = w_sp; m_start = 1; mode = 3; end
                    8'h3C: begin model_latch_window(); mode = 3; end
                    8'h01: begin model_window_reset(); m_ovr = 0; m_valid = 0; m_mv = 0; mode = 0; end
                    8'h00: ;
`ifdef LCD_WIN_CTRL_MADCTL_EN
                    8'h36: mode = 4;
`endif
                    default: mode = 0;
                endcase
            end else if (i_param_latch) begin
                if ((mode == 1 || mode == 2) && pidx < 4) begin
                    pb[pidx] = int'(i_param);
                    pidx++;
                    if (pidx == 4) begin
                        mdl_s = pb[0] * 256 + pb[1];
                        mdl_e = pb[2] * 256 + pb[3];
                        if (mode == 1) begin
                            m_sc = (mdl_s > H_RES - 1) ? H_RES - 1 : mdl_s;
                            m_ec = (mdl_e > H_RES - 1) ? H_RES - 1 : mdl_e;
                        end else begin
                            m_sp = (mdl_s > V_RES - 1) ? V_RES - 1 : mdl_s;
                            m_ep = (mdl_e > V_RES - 1) ? V_RES - 1 : mdl_e;
                        end
                    end
                end else if (mode == 4 && pidx == 0) begin
                    m_mv = i_param[5];
                    pidx = 1;
                end
            end else if (i_rgb565_latch && mode == 3) begin
                if (stall) m_ovr = 1;
                else begin
                    m_valid = 1; m_x = cx; m_y = cy; m_data = int'(i_rgb565);
                    m_done = (cx == w_ec) && (cy == w_ep);
                    model_advance();
                end
            end
        end
    end

    // ---------------- per-cycle compare and beat log ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("fb_valid", 32'(o_fb_valid), 32'(m_valid));
            check("frame_start", 32'(o_frame_start), 32'(m_start));
            check("frame_done", 32'(o_frame_done), 32'(m_done));
            check("overrun", 32'(o_overrun), 32'(m_ovr));
            if (m_valid) begin
                check("fb_x", 32'(o_fb_x), m_x);
                check("fb_y", 32'(o_fb_y), m_y);
                check("fb_data", 32'(o_fb_data), m_data);
            end
            if (o_fb_valid && i_fb_ready)
                log_q.push_back('{x: int'(o_fb_x), y: int'(o_fb_y), d: int'(o_fb_data), done: o_frame_done});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        i_command_latch = 1'b0;
        i_param_latch = 1'b0;
        i_rgb565_latch = 1'b0;
        i_rst = 1'b0;
        if (rand_rdy) i_fb_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
    endtask

    task automatic send_cmd(input logic [7:0] c);
        i_command = c; i_command_latch = 1'b1; step();
    endtask

    task automatic send_param(input logic [7:0] p);
        i_param = p; i_param_latch = 1'b1; step();
    endtask

    task automatic send_pix(input logic [15:0] d);
        i_rgb565 = d; i_rgb565_latch = 1'b1; step();
    endtask

    task automatic send_win(input logic [7:0] c, input int s, input int e, input int n);
        logic [7:0] b[5];
        b[0] = s[15:8]; b[1] = s[7:0]; b[2] = e[15:8]; b[3] = e[7:0]; b[4] = 8'($urandom);
        send_cmd(c);
        for (int i = 0; i < n; i++) send_param(b[i]);
    endtask

    task automatic check_beat(input string name, input int k, input int x, input int y, input bit done);
        if (k >= log_q.size()) begin
            check({name, "_present"}, 32'(log_q.size()), 32'(k + 1));
        end else begin
            check({name, "_x"}, log_q[k].x, x);
            check({name, "_y"}, log_q[k].y, y);
            check({name, "_done"}, 32'(log_q[k].done), 32'(done));
        end
    endtask

    function automatic logic [7:0] pick_cmd();
        case ($urandom_range(0, 7))
            0: return 8'h2A;
            1: return 8'h2B;
            2: return 8'h2C;
            3: return 8'h3C;
            4: return 8'h01;
            5: return 8'h00;
            6: return 8'h36;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic rand_win(input logic [7:0] c);
        int s, e, n, r;
        r = $urandom_range(0, 9);
        n = (r == 0) ? 3 : (r == 1) ? 5 : 4;
        s = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 24);
        e = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : s + $urandom_range(0, 3);
        send_win(c, s, e, n);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r;
        do_reset();
        chk_en = 1'b1;
        check("rst_valid", 32'(o_fb_valid), 32'd0);
        check("rst_x", 32'(o_fb_x), 32'd0);
        check("rst_y", 32'(o_fb_y), 32'd0);
        check("rst_data", 32'(o_fb_data), 32'd0);
        check("rst_flags", {29'd0, o_frame_start, o_frame_done, o_overrun}, 32'd0);

        // Basic 3x2 window frame
        i_fb_ready = 1'b1;
        send_win(8'h2A, 10, 12, 4);
        send_win(8'h2B, 5, 6, 4);
        send_cmd(8'h2C);
        check("start_after_ramwr", 32'(o_frame_start), 32'd1);
        log_q.delete();
        for (int i = 0; i < 6; i++) send_pix(16'h1000 + 16'(i));
        step();
        check("t1_count", 32'(log_q.size()), 32'd6);
        check_beat("t1_b0", 0, 10, 5, 0);
        check_beat("t1_b1", 1, 11, 5, 0);
        check_beat("t1_b2", 2, 12, 5, 0);
        check_beat("t1_b3", 3, 10, 6, 0);
        check_beat("t1_b4", 4, 11, 6, 0);
        check_beat("t1_b5", 5, 12, 6, 1);

        // Wrap, then continue with RAMWRC
        log_q.delete();
        send_cmd(8'h2C);
        for (int i = 0; i < 8; i++) send_pix(16'h2000 + 16'(i));
        send_cmd(8'h3C);
        send_pix(16'h2FFF);
        step();
        check("t2_count", 32'(log_q.size()), 32'd9);
        check_beat("t2_wrap", 6, 10, 5, 0);
        check_beat("t2_ramwrc", 8, 12, 5, 0);

        // Column clamp with start beyond H_RES
        do_reset();
        log_q.delete();
        send_win(8'h2A, 16'h01FF, 5, 4);
        send_cmd(8'h2C);
        send_pix(16'h3001);
        send_pix(16'h3002);
        step();
        check_beat("t3_b0", 0, 319, 0, 0);
        check_beat("t3_b1", 1, 319, 1, 0);

        // Stall: first beat held, second dropped
        i_fb_ready = 1'b0;
        send_cmd(8'h2C);
        send_pix(16'hA5A5);
        send_pix(16'h5A5A);
        step();
        check("t4_hold_valid", 32'(o_fb_valid), 32'd1);
        check("t4_hold_data", 32'(o_fb_data), 32'hA5A5);
        check("t4_hold_xy", {o_fb_x, o_fb_y}, {9'd319, 8'd0});
        check("t4_overrun", 32'(o_overrun), 32'd1);
        send_cmd(8'h01);
        check("t4_swreset_ovr", 32'(o_overrun), 32'd0);
        check("t4_swreset_valid", 32'(o_fb_valid), 32'd0);

        // Command and pixel together; short CASET
        i_fb_ready = 1'b1;
        send_win(8'h2A, 3, 4, 4);
        send_win(8'h2B, 2, 2, 4);
        send_cmd(8'h2C);
        log_q.delete();
        i_command = 8'h00; i_command_latch = 1'b1;
        i_rgb565 = 16'hBEEF; i_rgb565_latch = 1'b1;
        step();
        step();
        check("t5_no_beat", 32'(log_q.size()), 32'd0);
        send_win(8'h2A, 7, 9, 3);
        send_cmd(8'h2C);
        send_pix(16'h4444);
        step();
        check_beat("t5_short_caset", 0, 3, 2, 0);

        // Reset mid-stream with a pending beat
        i_fb_ready = 1'b0;
        send_pix(16'h7777);
        send_pix(16'h7778);
        do_reset();
        check("t6_valid", 32'(o_fb_valid), 32'd0);
        check("t6_outs", {7'd0, o_fb_x, o_fb_y, o_frame_start, o_frame_done, o_overrun}, 32'd0);
        check("t6_data", 32'(o_fb_data), 32'd0);
        i_fb_ready = 1'b1;
        log_q.delete();
        send_cmd(8'h3C);
        send_pix(16'h0101);
        step();
        check_beat("t6_cursor", 0, 0, 0, 0);

`ifdef LCD_WIN_CTRL_MADCTL_EN
        // Column-major traversal on a 2x2 window
        do_reset();
        send_win(8'h2A, 2, 3, 4);
        send_win(8'h2B, 4, 5, 4);
        send_cmd(8'h36);
        send_param(8'h20);
        log_q.delete();
        send_cmd(8'h2C);
        for (int i = 0; i < 4; i++) send_pix(16'h5000 + 16'(i));
        step();
        check_beat("mv_b0", 0, 2, 4, 0);
        check_beat("mv_b1", 1, 2, 5, 0);
        check_beat("mv_b2", 2, 3, 4, 0);
        check_beat("mv_b3", 3, 3, 5, 1);
`endif

        // Randomized traffic
        rand_rdy = 1'b1;
        for (int op = 0; op < 600; op++) begin
            r = $urandom_range(0, 99);
            if (r < 12)      rand_win(8'h2A);
            else if (r < 24) rand_win(8'h2B);
            else if (r < 34) send_cmd(8'h2C);
            else if (r < 39) send_cmd(8'h3C);
            else if (r < 75) begin
                for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
                    if ($urandom_range(0, 3) != 0) send_pix(16'($urandom));
                    else step();
                end
            end
            else if (r < 78) send_cmd(8'h01);
            else if (r < 81) send_cmd(8'h00);
            else if (r < 84) send_cmd(8'($urandom));
            else if (r < 87) begin
                send_cmd(8'h36);
                send_param(8'($urandom));
            end
            else if (r < 93) begin
                i_command = pick_cmd(); i_command_latch = 1'($urandom_range(0, 1));
                i_param = 8'($urandom); i_param_latch = 1'($urandom_range(0, 1));
                i_rgb565 = 16'($urandom); i_rgb565_latch = 1'b1;
                step();
            end
            else if (r < 95) do_reset();
            else if (r < 97) send_param(8'($urandom));
            else step();
        end
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
